sn74ls195a_serial_ctrl: RTL
===========================

// Module: sn74ls195a_serial_ctrl
// PURPOSE
//  Sequencer for one SN74LS195A-style 4-bit shift register (gates or behavioural model) used as a parallel-to-serial converter.
//  Accepts a word on a valid/ready port, loads it one nibble at a time via active-low PE, shifts each nibble out on Q3 MSB-first.
//  Sits between a word producer and the '195 instance; the '195 itself stays outside this block.
// PARAMETERS
//  NIBBLES  2     nibbles per word; word width = 4*NIBBLES; legal 1..8
//  FILL     1'b0  bit shifted into Q0 during shifts (drives J=K=FILL)
// PORTS
//  CP          in   1          clock, rising edge; same net as the '195 CP
//  MR          in   1          reset, synchronous, active-high (controller only; see chip_MRn)
//  in_data     in   4*NIBBLES  word to serialise; nibble NIBBLES-1 sent first
//  in_valid    in   1          word offered
//  in_ready    out  1          controller idle; transfer on in_valid && in_ready at CP edge
//  P           out  4          parallel data to '195 P[3:0]
//  PE          out  1          to '195 PE, active-low parallel load
//  J           out  1          to '195 J
//  K           out  1          to '195 K
//  chip_MRn    out  1          to '195 MR (active-low) = ~MR, combinational
//  Q3          in   1          from '195 Q3 (serial out)
//  sout        out  1          serial bit = Q3, valid when sout_valid
//  sout_valid  out  1          1 on each cycle carrying a word bit
//  done        out  1          1-cycle pulse on cycle carrying last bit of word
//  err         out  1          loopback mismatch, sticky (LOOPBACK_CHECK_EN only)
// BEHAVIOUR
//  - States: IDLE, LOAD, SHIFT. Registers: word buffer, nibble index nidx (0..NIBBLES-1), bit count bcnt (0..3).
//  - Reset (MR=1 at CP edge): state IDLE, in_ready=1, PE=1, J=K=FILL, P=0, nidx=0, bcnt=0, done=0, err=0; sout_valid=0.
//    Reset mid-word drops the word, no done pulse. chip_MRn=0 for every cycle MR=1 (clears the '195).
//  - IDLE: in_ready=1. On handshake: capture in_data, nidx=NIBBLES-1 -> LOAD. in_ready registered, =0 in LOAD/SHIFT.
//  - LOAD (1 cycle): PE=0, P=buffer[4*nidx+:4]; '195 loads at end of cycle -> SHIFT, bcnt=0.
//  - SHIFT (4 cycles, bcnt 0..3): PE=1, J=K=FILL, P don't-care (drive 0); sout_valid=1, sout=Q3.
//    Bits appear in order P[3],P[2],P[1],P[0]. At bcnt=3: if nidx==0 -> done=1, go IDLE; else nidx-- -> LOAD.
//  - Throughput: 5 cycles/nibble; latency handshake edge -> first sout_valid = 2 cycles (LOAD, then bit 0).
//  - in_valid while in_ready=0 ignored; in_data not re-sampled until next IDLE handshake. Min 1 IDLE cycle between words.
//  - '195 has no hold mode: PE=1 in IDLE also shifts FILL through; harmless, sout_valid=0 there.
//  - NIBBLES=1: single LOAD + 4 SHIFT, done on 4th bit.
// CONFIGURATION
//  LOOPBACK_CHECK_EN defined: each SHIFT cycle compares Q3 with expected bit buffer[4*nidx+3-bcnt];
//    mismatch sets err=1 on next edge; err held until MR. Catches wiring/model faults in the '195.
//  Not defined: no compare logic, err tied 0.
// STRUCTURE
//  Package sn195_ctrl_pkg: state_t enum {IDLE,LOAD,SHIFT}; NIBBLE_W=4; BIT_LAST=2'd3.
//  Sub-module sn195_loopback_chk (expected-bit compare + sticky err), instantiated only under LOOPBACK_CHECK_EN.
//  Nibble select, counters and FSM stay in the top module.
// TESTING  (bench: controller + SN74LS195Abehavior; repeat with SN74LS195Agates; CP period 10 ns)
//  1 Reset: MR=1 two edges -> in_ready=1, PE=1, chip_MRn=0, sout_valid=0, done=0, err=0; '195 Q=0000.
//  2 NIBBLES=2, in_data=8'hA5 one handshake -> LOAD P=4'hA, bits 1,0,1,0, LOAD P=4'h5, bits 0,1,0,1; done with last bit; 10 cycles.
//  3 in_valid held high with new data 8'h3C during word 8'hA5 -> 8'hA5 sent unaltered; 8'h3C accepted only after return to IDLE.
//  4 MR=1 during 2nd SHIFT cycle of first nibble -> IDLE next edge, no done, chip_MRn=0; next word 8'hFF sends eight 1s.
//  5 FILL=1, in_data=8'h00 -> sout all 0 for 8 valid bits; J=K=1 during SHIFT; in IDLE '195 Q fills to 1111.
//  6 LOOPBACK_CHECK_EN, force Q3=0 during word 8'h80 -> err=1 cycle after first bit, stays 1 until MR; without macro err=0.

Source files
------------

// File: rtl/sn74ls195a_serial_ctrl_pkg.sv
// Shared types and constants for the SN74LS195A serial sequencer.
// Optional feature macro used by this block: LOOPBACK_CHECK_EN.
package sn195_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int         NIBBLE_W = 4;
    localparam logic [1:0] BIT_LAST = 2'd3;

    // Width of the nibble index register; at least one bit even for one nibble.
    function automatic int idx_width(input int nibbles);
        if (nibbles > 1) begin
            return $clog2(nibbles);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/sn74ls195a_serial_ctrl_if.sv
// Word-side bus of the '195 sequencer: word input handshake plus serial
// output stream, done pulse and loopback error flag.
// Optional feature macro affecting err: LOOPBACK_CHECK_EN.
interface sn74ls195a_serial_ctrl_if
    import sn195_ctrl_pkg::*;
#(
    parameter int NIBBLES = 2
);
    logic [NIBBLE_W*NIBBLES-1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        sout;
    logic                        sout_valid;
    logic                        done;
    logic                        err;

    // Producer/consumer side of the controller.
    modport master (
        output in_data, in_valid,
        input  in_ready, sout, sout_valid, done, err
    );

    // Controller side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, sout, sout_valid, done, err
    );
endinterface

// File: rtl/sn74ls195a_serial_ctrl_loopback_chk.sv
// Loopback checker for the '195 sequencer: while a word bit is on Q3 it
// compares Q3 against the bit the buffer says should be there and raises a
// sticky error flag, cleared only by MR.
// Compiled only when LOOPBACK_CHECK_EN is defined.
`ifdef LOOPBACK_CHECK_EN
module sn195_loopback_chk
    import sn195_ctrl_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          active,
    input  logic [NIBBLE_W*NIBBLES-1:0]   word,
    input  logic [idx_width(NIBBLES)-1:0] nidx,
    input  logic [1:0]                    bcnt,
    input  logic                          q3,
    output logic                          err
);
    logic [NIBBLE_W-1:0] nib_s;
    logic                exp_s;
    logic                miss_s;
    logic                err_r;

    // Select the expected bit: nibble nidx, MSB first as bcnt advances.
    always_comb begin
        nib_s = word[NIBBLE_W*nidx +: NIBBLE_W];
        exp_s = nib_s[BIT_LAST - bcnt];
        if (active) begin
            miss_s = (q3 != exp_s);
        end else begin
            miss_s = 1'b0;
        end
    end

    // Sticky error flag, set the edge after a mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (miss_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;

endmodule
`endif

// File: rtl/sn74ls195a_serial_ctrl.sv
// Parallel-to-serial sequencer driving an external SN74LS195A: accepts a
// word, loads it a nibble at a time through active-low PE and streams each
// nibble MSB-first from Q3.  Optional macro LOOPBACK_CHECK_EN adds a Q3
// loopback compare; without it err is tied low.
module sn74ls195a_serial_ctrl
    import sn195_ctrl_pkg::*;
#(
    parameter int   NIBBLES = 2,
    parameter logic FILL    = 1'b0
) (
    input  logic                          CP,
    input  logic                          MR,
    sn74ls195a_serial_ctrl_if.slave       bus,
    output logic [3:0]                    P,
    output logic                          PE,
    output logic                          J,
    output logic                          K,
    output logic                          chip_MRn,
    input  logic                          Q3
);
    localparam int                  WORD_W    = NIBBLE_W * NIBBLES;
    localparam int                  NIDX_W    = idx_width(NIBBLES);
    localparam logic [NIDX_W-1:0]   NIDX_LAST = NIDX_W'(NIBBLES - 1);
    localparam logic [NIDX_W-1:0]   NIDX_ZERO = {NIDX_W{1'b0}};

    state_t              state_r, state_s;
    logic [WORD_W-1:0]   word_r, word_s;
    logic [NIDX_W-1:0]   nidx_r, nidx_s;
    logic [1:0]          bcnt_r, bcnt_s;
    logic                xfer_s;

    logic                in_ready_r, in_ready_s;
    logic                pe_r, pe_s;
    logic [3:0]          p_r, p_s;
    logic                sout_valid_r, sout_valid_s;
    logic                done_r, done_s;

    // Next-state logic: handshake capture, nibble/bit counters, FSM sequencing.
    always_comb begin
        state_s = state_r;
        word_s  = word_r;
        nidx_s  = nidx_r;
        bcnt_s  = bcnt_r;
        xfer_s  = bus.in_valid && in_ready_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    word_s  = bus.in_data;
                    nidx_s  = NIDX_LAST;
                    bcnt_s  = 2'd0;
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                bcnt_s  = 2'd0;
                state_s = SHIFT;
            end
            SHIFT: begin
                if (bcnt_r == BIT_LAST) begin
                    if (nidx_r == NIDX_ZERO) begin
                        state_s = IDLE;
                    end else begin
                        nidx_s  = nidx_r - NIDX_W'(1'b1);
                        state_s = LOAD;
                    end
                end else begin
                    bcnt_s = bcnt_r + 2'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        in_ready_s   = (state_s == IDLE);
        pe_s         = (state_s != LOAD);
        sout_valid_s = (state_s == SHIFT);
        done_s       = (state_s == SHIFT) && (bcnt_s == BIT_LAST) && (nidx_s == NIDX_ZERO);
        if (state_s == LOAD) begin
            p_s = word_s[NIBBLE_W*nidx_s +: NIBBLE_W];
        end else begin
            p_s = 4'h0;
        end
    end

    // State, datapath and output registers with synchronous MR.
    always_ff @(posedge CP) begin
        if (MR) begin
            state_r      <= IDLE;
            word_r       <= {WORD_W{1'b0}};
            nidx_r       <= NIDX_ZERO;
            bcnt_r       <= 2'd0;
            in_ready_r   <= 1'b1;
            pe_r         <= 1'b1;
            p_r          <= 4'h0;
            sout_valid_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            word_r       <= word_s;
            nidx_r       <= nidx_s;
            bcnt_r       <= bcnt_s;
            in_ready_r   <= in_ready_s;
            pe_r         <= pe_s;
            p_r          <= p_s;
            sout_valid_r <= sout_valid_s;
            done_r       <= done_s;
        end
    end

    // J and K only matter while shifting; holding them at FILL keeps the
    // '195 shifting FILL into Q0 in every non-load cycle.
    assign J          = FILL;
    assign K          = FILL;
    assign chip_MRn   = ~MR;
    assign P          = p_r;
    assign PE         = pe_r;
    assign bus.in_ready   = in_ready_r;
    assign bus.sout       = Q3;
    assign bus.sout_valid = sout_valid_r;
    assign bus.done       = done_r;

`ifdef LOOPBACK_CHECK_EN
    sn195_loopback_chk #(
        .NIBBLES (NIBBLES)
    ) u_loopback_chk (
        .clk    (CP),
        .rst    (MR),
        .active (sout_valid_r),
        .word   (word_r),
        .nidx   (nidx_r),
        .bcnt   (bcnt_r),
        .q3     (Q3),
        .err    (bus.err)
    );
`else
    assign bus.err = 1'b0;
`endif

endmodule
